// File: rtl/jtoutrun_obj_dispatch_pkg.sv
// Shared definitions for the OutRun sprite command dispatcher.
// Holds the draw-command field map (also used by the line scanner that
// packs cmd_in), the sequencer state encoding and small helpers.
package jtoutrun_obj_dispatch_pkg;

  // Command word width; the field map below fills it exactly.
  localparam int CW = 50;

  // cmd_in = {backwd,hflip,hzoom,pal,shadow,prio,bank,offset,xpos}
  localparam int XPOS_LSB   = 0;
  localparam int XPOS_W     = 9;
  localparam int OFFSET_LSB = 9;
  localparam int OFFSET_W   = 16;
  localparam int BANK_LSB   = 25;
  localparam int BANK_W     = 3;
  localparam int PRIO_LSB   = 28;
  localparam int PRIO_W     = 2;
  localparam int SHADOW_BIT = 30;
  localparam int PAL_LSB    = 31;
  localparam int PAL_W      = 7;
  localparam int HZOOM_LSB  = 38;
  localparam int HZOOM_W    = 10;
  localparam int HFLIP_BIT  = 48;
  localparam int BACKWD_BIT = 49;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT_UP = 2'd2,
    ST_WAIT_DN = 2'd3
  } state_t;

  // WAIT_UP gives up on its third silent cycle, so together with the
  // LAUNCH cycle the engine gets four cycles to raise busy.
  localparam logic [1:0] WAIT_UP_LAST = 2'd2;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  // Saturating increment for the 8-bit drop counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == DROP_MAX) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/jtoutrun_obj_dispatch_if.sv
// Scanner/draw-engine bus of the sprite dispatcher.
//   push, cmd_in : scanner -> dispatcher command write
//   full         : dispatcher -> scanner, queue holds 2**AW entries
//   draw_start   : dispatcher -> engine, one-cycle start pulse
//   draw_busy    : engine -> dispatcher, engine is drawing
//   xpos..backwd : dispatcher -> engine, fields of the current sprite
// master = scanner/engine side, slave = dispatcher.
interface jtoutrun_obj_dispatch_if;
  import jtoutrun_obj_dispatch_pkg::*;

  logic          push;
  logic [CW-1:0] cmd_in;
  logic          full;
  logic          draw_start;
  logic          draw_busy;
  logic [8:0]    xpos;
  logic [15:0]   offset;
  logic [2:0]    bank;
  logic [1:0]    prio;
  logic          shadow;
  logic [6:0]    pal;
  logic [9:0]    hzoom;
  logic          hflip;
  logic          backwd;

  modport master (
    output push, cmd_in, draw_busy,
    input  full, draw_start, xpos, offset, bank, prio, shadow, pal, hzoom, hflip, backwd
  );

  modport slave (
    input  push, cmd_in, draw_busy,
    output full, draw_start, xpos, offset, bank, prio, shadow, pal, hzoom, hflip, backwd
  );

endinterface

// File: rtl/jtoutrun_obj_dispatch_fifo.sv
// Synchronous command FIFO with a registered read port.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : empties the queue; a push in the same cycle is discarded
//   push/wdata : write request (accepted when not full, or when popping)
//   pop        : moves the head into rdata
//   rdata      : registered head; only changes on a pop (kept on flush)
//   full/empty : occupancy flags
module jtoutrun_obj_dispatch_fifo #(
  parameter int AW = 3,
  parameter int DW = 50
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int             DEPTH    = 2**AW;
  localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];
  localparam logic [AW-1:0]  PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]    CNT_ONE  = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == {(AW+1){1'b0}});

  // Qualify requests: flush wins, a full queue accepts a write only
  // when the head leaves in the same cycle.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (flush) begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
    end else begin
      do_push_s = push && (!full || pop);
      do_pop_s  = pop && !empty;
    end
  end

  // Storage array; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wptr_r <= wptr_r + PTR_ONE;
      if (do_pop_s)  rptr_r <= rptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered read port; it doubles as the sprite field register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= {DW{1'b0}};
    end else if (do_pop_s) begin
      rdata <= mem_r[rptr_r];
    end
  end

endmodule

// File: rtl/jtoutrun_obj_dispatch.sv
// OutRun sprite command dispatcher: queues scanner draw commands and
// issues them one at a time to the draw engine.
//   clk, rst_n : clock, synchronous active-low reset
//   hstart     : line start; flushes the queue and aborts sequencing
//   bus        : scanner/engine bus (push, cmd_in, full, draw_start,
//                draw_busy and the current sprite fields)
//   idle       : queue empty and sequencer idle
//   line_drops : commands dropped during the previous line
module jtoutrun_obj_dispatch
  import jtoutrun_obj_dispatch_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hstart,
  jtoutrun_obj_dispatch_if.slave  bus,
  output logic                    idle,
  output logic [7:0]              line_drops
);

  state_t        state_r;
  logic          draw_start_r;
  logic [1:0]    wait_cnt_r;
  logic [7:0]    drop_cnt_r;
  logic [CW-1:0] field_s;
  logic          full_s;
  logic          empty_s;
  logic          pop_s;
  logic          drop_s;

  jtoutrun_obj_dispatch_fifo #(
    .AW (AW),
    .DW (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (hstart),
    .push  (bus.push),
    .wdata (bus.cmd_in),
    .pop   (pop_s),
    .rdata (field_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Pop only from IDLE; a push refused by a full queue with no pop
  // is a drop, except during hstart where the push is simply ignored.
  always_comb begin
    pop_s  = 1'b0;
    drop_s = 1'b0;
    if (hstart) begin
      pop_s  = 1'b0;
      drop_s = 1'b0;
    end else begin
      pop_s  = (state_r == ST_IDLE) && !empty_s;
      drop_s = bus.push && full_s && !pop_s;
    end
  end

  // Sequencer: start pulse, wait for busy to rise then fall, with a
  // timeout in case the engine never acknowledges.
  always_ff @(posedge clk) begin
    if (!rst_n || hstart) begin
      state_r      <= ST_IDLE;
      draw_start_r <= 1'b0;
      wait_cnt_r   <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            draw_start_r <= 1'b1;
            state_r      <= ST_LAUNCH;
          end else begin
            draw_start_r <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          draw_start_r <= 1'b0;
          wait_cnt_r   <= 2'd0;
          state_r      <= ST_WAIT_UP;
        end
        ST_WAIT_UP: begin
          if (bus.draw_busy) begin
            state_r <= ST_WAIT_DN;
          end else if (wait_cnt_r == WAIT_UP_LAST) begin
            state_r <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
          end
        end
        ST_WAIT_DN: begin
          if (!bus.draw_busy) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          draw_start_r <= 1'b0;
        end
      endcase
    end
  end

  // Drop counter for the current line; latched and cleared at hstart.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_r <= 8'd0;
      line_drops <= 8'd0;
    end else if (hstart) begin
      line_drops <= drop_cnt_r;
      drop_cnt_r <= 8'd0;
    end else if (drop_s) begin
      drop_cnt_r <= sat_inc(drop_cnt_r);
    end
  end

  assign idle           = empty_s && (state_r == ST_IDLE);
  assign bus.full       = full_s;
  assign bus.draw_start = draw_start_r;
  assign bus.xpos       = field_s[XPOS_LSB +: XPOS_W];
  assign bus.offset     = field_s[OFFSET_LSB +: OFFSET_W];
  assign bus.bank       = field_s[BANK_LSB +: BANK_W];
  assign bus.prio       = field_s[PRIO_LSB +: PRIO_W];
  assign bus.shadow     = field_s[SHADOW_BIT];
  assign bus.pal        = field_s[PAL_LSB +: PAL_W];
  assign bus.hzoom      = field_s[HZOOM_LSB +: HZOOM_W];
  assign bus.hflip      = field_s[HFLIP_BIT];
  assign bus.backwd     = field_s[BACKWD_BIT];

endmodule

// File: tb/tb_jtoutrun_obj_dispatch.sv
// Self-checking bench for jtoutrun_obj_dispatch. A simple draw-engine
// model raises busy the cycle after each start for busy_len cycles
// (busy_len = 0: never raises). A monitor records every issued command
// and the cycle it started; tests compare those against a plain queue
// of what the scanner pushed.
module tb_jtoutrun_obj_dispatch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hstart;
  logic       idle;
  logic [7:0] line_drops;

  int n_cmp = 0;
  int n_err = 0;
  int busy_len = 0;
  int busy_cnt = 0;
  int cyc = 0;
  int hold_viol = 0;

  logic [49:0] exp_q[$];
  logic [49:0] obs_q[$];
  int          obs_t[$];
  logic [49:0] last_f;

  always #5 clk = ~clk;

  jtoutrun_obj_dispatch_if bus();

  jtoutrun_obj_dispatch #(.AW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hstart     (hstart),
    .bus        (bus),
    .idle       (idle),
    .line_drops (line_drops)
  );

  function automatic logic [49:0] fields_now();
    return {bus.backwd, bus.hflip, bus.hzoom, bus.pal, bus.shadow,
            bus.prio, bus.bank, bus.offset, bus.xpos};
  endfunction

  function automatic logic [49:0] rand_cmd(input logic [8:0] x);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    r[8:0] = x;
    return r[49:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Draw engine model.
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.draw_busy <= 1'b0;
      busy_cnt      <= 0;
    end else if (bus.draw_start && busy_len > 0) begin
      bus.draw_busy <= 1'b1;
      busy_cnt      <= busy_len;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      bus.draw_busy <= 1'b0;
      busy_cnt      <= 0;
    end
  end

  // Monitor: record starts; fields may only move together with a start.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_f = '0;
    end else if (bus.draw_start === 1'b1) begin
      last_f = fields_now();
      obs_q.push_back(last_f);
      obs_t.push_back(cyc);
    end else if (fields_now() !== last_f) begin
      hold_viol++;
    end
  end

  task automatic push_cmd(input logic [49:0] c);
    bus.push   = 1'b1;
    bus.cmd_in = c;
    @(negedge clk);
    bus.push   = 1'b0;
  endtask

  task automatic pulse_hstart();
    hstart = 1'b1;
    @(negedge clk);
    hstart = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k = 0;
    ok = 1'b0;
    while (k < budget) begin
      if (idle === 1'b1 && bus.draw_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic settle(output bit ok);
    wait_idle(600, ok);
    pulse_hstart();
    obs_q.delete();
    obs_t.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hstart = 1'b0; bus.push = 1'b0; bus.cmd_in = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.draw_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", bus.draw_start); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_cmp++; if (line_drops !== 8'd0) begin n_err++; $display("FAIL reset_drops: got %0d want 0", line_drops); end
    n_cmp++; if (fields_now() !== 50'd0) begin n_err++; $display("FAIL reset_fields: got %h want 0", fields_now()); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Fixed xpos 10/20/30 round, then random rounds of up to 8 commands.
  task automatic test_basic();
    bit ok;
    int n;
    for (int r = 0; r < 6; r++) begin
      settle(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_settle: round %0d not idle", r); end
      n = (r == 0) ? 3 : int'($urandom_range(1, 8));
      busy_len = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        logic [49:0] c;
        c = rand_cmd((r == 0) ? 9'(10 * (i + 1)) : 9'($urandom_range(0, 511)));
        exp_q.push_back(c);
        push_cmd(c);
      end
      wait_idle(200, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_done: round %0d timeout idle=%b", r, idle); end
      n_cmp++; if (obs_q.size() != n) begin n_err++; $display("FAIL basic_count: round %0d got %0d want %0d", r, obs_q.size(), n); end
      for (int i = 0; i < n; i++) begin
        if (i < obs_q.size()) begin
          n_cmp++;
          if (obs_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL basic_cmd: round %0d idx %0d got %h want %h", r, i, obs_q[i], exp_q[i]);
          end
        end
      end
    end
    n_cmp++; if (hold_viol != 0) begin n_err++; $display("FAIL basic_hold: got %0d changes want 0", hold_viol); end
  endtask

  task automatic test_overflow();
    bit ok;
    settle(ok);
    busy_len = 100;
    push_cmd(rand_cmd(9'd1));
    wait_obs(1, 20, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_primer: got no start want 1"); end
    obs_q.delete();
    for (int i = 1; i <= 10; i++) begin
      push_cmd(rand_cmd(9'(i)));
      if (i == 7) begin
        n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL ovf_full7: got %b want 0", bus.full); end
      end
      if (i == 8) begin
        n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL ovf_full8: got %b want 1", bus.full); end
      end
    end
    pulse_hstart();
    n_cmp++; if (line_drops !== 8'd2) begin n_err++; $display("FAIL ovf_drops: got %0d want 2", line_drops); end
    n_cmp++; if (bus.full !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL ovf_flush: got full=%b idle=%b want 0/1", bus.full, idle); end
    wait_idle(200, ok);
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL ovf_nostart: got %0d starts want 0", obs_q.size()); end
  endtask

  task automatic test_same_cycle();
    bit ok;
    bit got;
    int n_push;
    logic [49:0] c;
    settle(ok);
    busy_len = 30;
    push_cmd(rand_cmd(9'd100));
    wait_obs(1, 20, ok);
    obs_q.delete();
    for (int i = 0; i < 8; i++) begin
      c = rand_cmd(9'($urandom_range(0, 511)));
      exp_q.push_back(c);
      push_cmd(c);
    end
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL same_full: got %b want 1", bus.full); end
    busy_len = 2;
    for (int k = 0; k < 60 && bus.draw_busy === 1'b1; k++) @(negedge clk);
    // Keep pushing until the cycle the head is popped.
    n_push = 0;
    got = 1'b0;
    while (n_push < 10) begin
      c = rand_cmd(9'($urandom_range(0, 511)));
      bus.push = 1'b1; bus.cmd_in = c;
      @(negedge clk);
      n_push++;
      if (bus.draw_start === 1'b1) begin got = 1'b1; break; end
    end
    bus.push = 1'b0;
    n_cmp++; if (!got) begin n_err++; $display("FAIL same_pop: got no start want 1"); end
    exp_q.push_back(c);
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL same_count: got full=%b want 1", bus.full); end
    wait_idle(200, ok);
    n_cmp++; if (obs_q.size() != 9) begin n_err++; $display("FAIL same_issued: got %0d want 9", obs_q.size()); end
    for (int i = 0; i < 9; i++) begin
      if (i < obs_q.size()) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL same_cmd: idx %0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
    pulse_hstart();
    n_cmp++; if (line_drops !== 8'(n_push - 1)) begin n_err++; $display("FAIL same_drops: got %0d want %0d", line_drops, n_push - 1); end
  endtask

  task automatic test_hstart();
    bit ok;
    logic [49:0] prim;
    settle(ok);
    busy_len = 20;
    prim = rand_cmd(9'd77);
    push_cmd(prim);
    for (int i = 0; i < 5; i++) push_cmd(rand_cmd(9'(i)));
    n_cmp++; if (bus.draw_busy !== 1'b1) begin n_err++; $display("FAIL hs_busy: got %b want 1", bus.draw_busy); end
    hstart = 1'b1; bus.push = 1'b1; bus.cmd_in = rand_cmd(9'd5);
    @(negedge clk);
    hstart = 1'b0; bus.push = 1'b0;
    n_cmp++; if (idle !== 1'b1 || bus.full !== 1'b0) begin n_err++; $display("FAIL hs_flush: got idle=%b full=%b want 1/0", idle, bus.full); end
    n_cmp++; if (fields_now() !== prim) begin n_err++; $display("FAIL hs_fields: got %h want %h", fields_now(), prim); end
    repeat (40) @(negedge clk);
    n_cmp++; if (obs_q.size() != 1) begin n_err++; $display("FAIL hs_nostart: got %0d starts want 1", obs_q.size()); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL hs_idle: got %b want 1", idle); end
    pulse_hstart();
    n_cmp++; if (line_drops !== 8'd0) begin n_err++; $display("FAIL hs_drops: got %0d want 0", line_drops); end
    n_cmp++; if (hold_viol != 0) begin n_err++; $display("FAIL hs_hold: got %0d changes want 0", hold_viol); end
  endtask

  task automatic test_no_busy();
    bit ok;
    settle(ok);
    busy_len = 0;
    for (int i = 0; i < 3; i++) begin
      logic [49:0] c;
      c = rand_cmd(9'(200 + i));
      exp_q.push_back(c);
      push_cmd(c);
    end
    wait_idle(100, ok);
    n_cmp++; if (!ok || obs_q.size() != 3) begin n_err++; $display("FAIL nobusy_count: got %0d starts idle=%b want 3/1", obs_q.size(), idle); end
    for (int i = 0; i < 3; i++) begin
      if (i < obs_q.size()) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL nobusy_cmd: idx %0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      if (i > 0 && i < obs_t.size()) begin
        n_cmp++;
        if (obs_t[i] - obs_t[i-1] != 5) begin n_err++; $display("FAIL nobusy_gap: idx %0d got %0d want 5", i, obs_t[i] - obs_t[i-1]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    settle(ok);
    busy_len = 50;
    push_cmd(rand_cmd(9'd300));
    push_cmd(rand_cmd(9'd301));
    repeat (3) @(negedge clk);
    obs_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.draw_start !== 1'b0 || bus.full !== 1'b0) begin n_err++; $display("FAIL rmid_ctl: got start=%b full=%b want 0/0", bus.draw_start, bus.full); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rmid_idle: got %b want 1", idle); end
    n_cmp++; if (fields_now() !== 50'd0) begin n_err++; $display("FAIL rmid_fields: got %h want 0", fields_now()); end
    n_cmp++; if (line_drops !== 8'd0) begin n_err++; $display("FAIL rmid_drops: got %0d want 0", line_drops); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL rmid_nostart: got %0d starts want 0", obs_q.size()); end
  endtask

  task automatic test_saturate();
    bit ok;
    settle(ok);
    busy_len = 400;
    push_cmd(rand_cmd(9'd0));
    wait_obs(1, 20, ok);
    for (int i = 0; i < 300; i++) push_cmd(rand_cmd(9'($urandom_range(0, 511))));
    n_cmp++; if (line_drops !== 8'd0) begin n_err++; $display("FAIL sat_pre: got %0d want 0", line_drops); end
    pulse_hstart();
    n_cmp++; if (line_drops !== 8'd255) begin n_err++; $display("FAIL sat_drops: got %0d want 255", line_drops); end
    wait_idle(600, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL sat_idle: got idle=%b busy=%b want 1/0", idle, bus.draw_busy); end
    pulse_hstart();
    n_cmp++; if (line_drops !== 8'd0) begin n_err++; $display("FAIL sat_clear: got %0d want 0", line_drops); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_same_cycle();
    test_hstart();
    test_no_busy();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
